// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Bundles the byte-queue signals between the host/PISO side and the
//   uart_tx_fifo buffer.
//   Ports (signals):
//     wr_en, wr_data[7:0]     host write request and byte
//     rd_en                   PISO pop request (one pulse per frame)
//     parity_odd              0 = even parity, 1 = odd parity
//     data_out[7:0], parity   head byte and its parity bit
//     fifo_empty, fifo_full   occupancy flags
//     count[AW:0]             number of stored bytes
//     overflow, underflow     one-cycle pulses for dropped write / ignored read
//   Modports: master = host/PISO side, slave = the FIFO.
interface uart_tx_fifo_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          rd_en;
    logic          parity_odd;
    logic [7:0]    data_out;
    logic          parity;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output wr_en, wr_data, rd_en, parity_odd,
        input  data_out, parity, fifo_empty, fifo_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, parity_odd,
        output data_out, parity, fifo_empty, fifo_full, count, overflow, underflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   First-word-fall-through byte queue with parity generation, sitting
//   directly upstream of the UART PISO serialiser.
//   Ports:
//     bd_clk   baud-rate clock, all state on the rising edge
//     rst_n    asynchronous active-low reset (clears pointers/count/pulses)
//     bus      uart_tx_fifo_if.slave: write/pop handshake, head byte,
//              parity, flags, count and overflow/underflow pulses
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            bd_clk,
    input  logic            rst_n,
    uart_tx_fifo_if.slave   bus
);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          underflow_q;

    logic          empty;
    logic          full;
    logic          wr_ok;
    logic          rd_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // A pop in the same cycle frees a slot, so a write to a full queue
    // still succeeds when the PISO is popping.
    assign wr_ok = bus.wr_en & (~full | bus.rd_en);
    assign rd_ok = bus.rd_en & ~empty;

    // Storage is deliberately not reset; contents are don't-care while empty.
    always_ff @(posedge bd_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge bd_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            overflow_q  <= bus.wr_en & ~wr_ok;
            underflow_q <= bus.rd_en & ~rd_ok;
        end
    end

    // Head byte is a combinational read so a byte written into an empty
    // queue is visible right after its write edge. Only rd_en moves rd_ptr,
    // so the head stays stable while the PISO samples it.
    assign bus.data_out   = mem[rd_ptr];
    assign bus.parity     = (^mem[rd_ptr]) ^ bus.parity_odd;
    assign bus.fifo_empty = empty;
    assign bus.fifo_full  = full;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed self-checking bench for uart_tx_fifo. Inputs change on the
//   falling edge of bd_clk; outputs are sampled on the falling edge.
module tb_uart_tx_fifo;
    logic bd_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    logic tx     = 1'b1;

    uart_tx_fifo_if #(.AW(4)) bus ();

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .bd_clk (bd_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 bd_clk = ~bd_clk;

    task automatic push(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(negedge bd_clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(negedge bd_clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge bd_clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rst_n     = 1'b0;
        @(negedge bd_clk);
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        bus.wr_en      = 1'b1;
        bus.wr_data    = 8'hA5;
        bus.rd_en      = 1'b0;
        bus.parity_odd = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(negedge bd_clk);
        n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", bus.fifo_empty); end
        n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        n_vec++; if (bus.fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", bus.fifo_full); end
        n_vec++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_err++; $display("FAIL reset_pulses got=%b%b exp=00", bus.overflow, bus.underflow); end
        rst_n = 1'b1;
        @(negedge bd_clk);
        bus.wr_en = 1'b0;
        n_vec++; if (bus.count !== 5'd1) begin n_err++; $display("FAIL reset_first_write_count got=%0d exp=1", bus.count); end
        n_vec++; if (bus.data_out !== 8'hA5) begin n_err++; $display("FAIL reset_first_write_data got=%h exp=a5", bus.data_out); end
        // asynchronous reset in the middle of the low phase
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.count !== 5'd0 || bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL async_reset got count=%0d empty=%b exp 0/1", bus.count, bus.fifo_empty); end
        @(negedge bd_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_parity();
        bus.parity_odd = 1'b0;
        push(8'hA5);
        n_vec++; if (bus.data_out !== 8'hA5) begin n_err++; $display("FAIL parity_data got=%h exp=a5", bus.data_out); end
        n_vec++; if (bus.parity !== 1'b0) begin n_err++; $display("FAIL parity_even_a5 got=%b exp=0", bus.parity); end
        bus.parity_odd = 1'b1;
        #1;
        n_vec++; if (bus.parity !== 1'b1) begin n_err++; $display("FAIL parity_odd_a5 got=%b exp=1", bus.parity); end
        bus.parity_odd = 1'b0;
        pop();
        push(8'h07);
        n_vec++; if (bus.data_out !== 8'h07) begin n_err++; $display("FAIL parity_data_07 got=%h exp=07", bus.data_out); end
        n_vec++; if (bus.parity !== 1'b1) begin n_err++; $display("FAIL parity_even_07 got=%b exp=1", bus.parity); end
        pop();
        n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL parity_drain_empty got=%b exp=1", bus.fifo_empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push(8'(i));
        n_vec++; if (bus.fifo_full !== 1'b1 || bus.count !== 5'd16) begin n_err++; $display("FAIL ovf_fill got full=%b count=%0d exp 1/16", bus.fifo_full, bus.count); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early_pulse got=%b exp=0", bus.overflow); end
        push(8'hFF);
        n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse got=%b exp=1", bus.overflow); end
        n_vec++; if (bus.count !== 5'd16) begin n_err++; $display("FAIL ovf_count got=%0d exp=16", bus.count); end
        @(negedge bd_clk);
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pulse_clear got=%b exp=0", bus.overflow); end
        for (int i = 0; i < 16; i++) begin
            n_vec++; if (bus.data_out !== 8'(i)) begin n_err++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, bus.data_out, 8'(i)); end
            pop();
        end
        n_vec++; if (bus.fifo_empty !== 1'b1 || bus.count !== 5'd0) begin n_err++; $display("FAIL ovf_drained got empty=%b count=%0d exp 1/0", bus.fifo_empty, bus.count); end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) push(8'(i));
        n_vec++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL simul_head got=%h exp=00", bus.data_out); end
        bus.rd_en = 1'b1;
        push(8'h55);
        bus.rd_en = 1'b0;
        n_vec++; if (bus.count !== 5'd16 || bus.fifo_full !== 1'b1) begin n_err++; $display("FAIL simul_count got=%0d full=%b exp 16/1", bus.count, bus.fifo_full); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL simul_no_ovf got=%b exp=0", bus.overflow); end
        for (int i = 1; i < 17; i++) begin
            n_vec++;
            if (bus.data_out !== ((i == 16) ? 8'h55 : 8'(i))) begin
                n_err++; $display("FAIL simul_drain_%0d got=%h exp=%h", i, bus.data_out, (i == 16) ? 8'h55 : 8'(i));
            end
            pop();
        end
        n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL simul_drained got=%b exp=1", bus.fifo_empty); end
    endtask

    task automatic test_underflow();
        pop();
        n_vec++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL udf_pulse got=%b exp=1", bus.underflow); end
        n_vec++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL udf_count got=%0d exp=0", bus.count); end
        @(negedge bd_clk);
        n_vec++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL udf_clear got=%b exp=0", bus.underflow); end
        bus.rd_en = 1'b1;
        push(8'h3C);
        bus.rd_en = 1'b0;
        n_vec++; if (bus.count !== 5'd1 || bus.fifo_empty !== 1'b0) begin n_err++; $display("FAIL udf_wr_count got=%0d empty=%b exp 1/0", bus.count, bus.fifo_empty); end
        n_vec++; if (bus.data_out !== 8'h3C) begin n_err++; $display("FAIL udf_wr_data got=%h exp=3c", bus.data_out); end
        n_vec++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL udf_wr_pulse got=%b exp=1", bus.underflow); end
        pop();
    endtask

    task automatic test_loopback();
        logic [10:0] exp_frame [2];
        logic [10:0] cap;
        logic [7:0]  d;
        logic        p;
        // bit i is the i-th bit on the line: start, d0..d7, parity, stop
        exp_frame[0] = 11'b1_0_01001000_0;
        exp_frame[1] = 11'b1_1_01001001_0;
        bus.parity_odd = 1'b0;
        push(8'h48);
        push(8'h49);
        for (int f = 0; f < 2; f++) begin
            n_vec++; if (bus.fifo_empty !== 1'b0) begin n_err++; $display("FAIL loop_ready_%0d got empty=%b exp=0", f, bus.fifo_empty); end
            d = bus.data_out;
            p = bus.parity;
            pop();
            for (int b = 0; b < 11; b++) begin
                if (b == 0)       tx = 1'b0;
                else if (b < 9)   tx = d[b-1];
                else if (b == 9)  tx = p;
                else              tx = 1'b1;
                cap[b] = tx;
                @(negedge bd_clk);
            end
            n_vec++; if (cap !== exp_frame[f]) begin n_err++; $display("FAIL loop_frame_%0d got=%b exp=%b", f, cap, exp_frame[f]); end
        end
        n_vec++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL loop_empty_after got=%b exp=1", bus.fifo_empty); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.wr_en      = 1'b0;
        bus.wr_data    = 8'h00;
        bus.rd_en      = 1'b0;
        bus.parity_odd = 1'b0;
        test_reset();
        do_reset();
        test_parity();
        do_reset();
        test_overflow();
        do_reset();
        test_simul_full();
        do_reset();
        test_underflow();
        do_reset();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
